// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Sequential MIPS instruction encoder. Symbolic instructions (mnemonic ID plus
// register/immediate/target fields) are accepted over a valid/ready handshake,
// encoded combinationally into 32-bit machine words, buffered in a small FIFO
// and streamed to an instruction-memory load port with an auto-incrementing
// byte address.
//
// Mnemonic IDs: 0 add, 1 sub, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 jal, 8 jr,
// 9 sll. IDs 10..15 are illegal.
//
// Optional feature macro: ENC_ILLEGAL_TRAP_EN
//   defined   : illegal mnemonics complete the handshake, are not pushed,
//               and set the sticky err flag.
//   undefined : illegal mnemonics encode as 32'h0 (nop) and are pushed.
//
// Parameters
//   DEPTH     : FIFO entries (power of two, >= 2)
//   BASE_ADDR : byte address of the first emitted word
//
// Ports
//   clk        in   1  clock, rising edge
//   reset      in   1  synchronous active-low reset
//   start      in   1  one-cycle pulse that begins a program
//   in_valid   in   1  instruction present
//   in_ready   out  1  encoder accepts this cycle
//   in_mnem    in   4  mnemonic ID
//   in_rs      in   5  rs field
//   in_rt      in   5  rt field
//   in_rd      in   5  rd field
//   in_shamt   in   5  shift amount
//   in_imm     in  16  immediate
//   in_target  in  26  jal target field
//   in_last    in   1  final instruction of the program
//   out_valid  out  1  word present on out_addr/out_wdata
//   out_ready  in   1  load port consumes the word
//   out_addr   out 32  byte address of the current word
//   out_wdata  out 32  encoded word (FIFO head)
//   done       out  1  program fully emitted
//   err        out  1  sticky illegal-mnemonic flag
//   count      out 16  words emitted since start (wraps)
//
// FSM states
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | accepting instructions and emitting words
//   DONE  | last instruction accepted and FIFO drained
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  output logic        done,
  output logic        err,
  output logic [15:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   LP_FULL  = DEPTH[AW:0];
  localparam logic [AW:0]   LP_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LP_PINC  = {{(AW-1){1'b0}}, 1'b1};

  // Mnemonic IDs
  localparam logic [3:0] M_ADD = 4'd0;
  localparam logic [3:0] M_SUB = 4'd1;
  localparam logic [3:0] M_ORI = 4'd2;
  localparam logic [3:0] M_LW  = 4'd3;
  localparam logic [3:0] M_SW  = 4'd4;
  localparam logic [3:0] M_BEQ = 4'd5;
  localparam logic [3:0] M_LUI = 4'd6;
  localparam logic [3:0] M_JAL = 4'd7;
  localparam logic [3:0] M_JR  = 4'd8;
  localparam logic [3:0] M_SLL = 4'd9;

  // Opcodes and function codes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_SLL   = 6'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_occ;
  logic [31:0]   r_addr;
  logic [15:0]   r_count;
  logic          r_err;
  logic          r_last_seen;

  logic [31:0]   w_word;
  logic          w_empty;
  logic          w_full;
  logic          w_acc;
  logic          w_trap;
  logic          w_push;
  logic          w_pop;
  logic          w_start_ok;

  // -------------------------------------------------------------------------
  // Combinational encoder; unused fields are forced to zero.
  // -------------------------------------------------------------------------
  always_comb begin
    w_word = 32'h0000_0000;
    case (in_mnem)
      M_ADD: w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADD};
      M_SUB: w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUB};
      M_ORI: w_word = {OP_ORI, in_rs, in_rt, in_imm};
      M_LW:  w_word = {OP_LW,  in_rs, in_rt, in_imm};
      M_SW:  w_word = {OP_SW,  in_rs, in_rt, in_imm};
      M_BEQ: w_word = {OP_BEQ, in_rs, in_rt, in_imm};
      M_LUI: w_word = {OP_LUI, 5'd0, in_rt, in_imm};
      M_JAL: w_word = {OP_JAL, in_target};
      M_JR:  w_word = {OP_RTYPE, in_rs, 15'd0, FN_JR};
      M_SLL: w_word = {OP_RTYPE, 5'd0, in_rt, in_rd, in_shamt, FN_SLL};
      default: w_word = 32'h0000_0000;
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  assign w_empty  = (r_occ == '0);
  assign w_full   = (r_occ == LP_FULL);
  assign in_ready = (r_state == RUN) && !w_full && !r_last_seen;
  assign w_acc    = in_valid && in_ready;
  assign w_pop    = !w_empty && out_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
  logic w_legal;
  assign w_legal = (in_mnem <= M_SLL);
  // Illegal instructions complete the handshake but never reach the FIFO.
  assign w_trap  = w_acc && !w_legal;
`else
  assign w_trap  = 1'b0;
`endif

  assign w_push     = w_acc && !w_trap;
  assign w_start_ok = start && (r_state != RUN);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        // Enter DONE right after the pop that drains the FIFO, or straight
        // away if the FIFO is already empty once the last instruction is in.
        // No push can coincide here because in_ready is low after last.
        if (r_last_seen && (w_empty || (r_occ == LP_ONE && w_pop))) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PINC;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PINC;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + LP_ONE;
        2'b01:   r_occ <= r_occ - LP_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Address, count, flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr      <= BASE_ADDR;
      r_count     <= 16'd0;
      r_err       <= 1'b0;
      r_last_seen <= 1'b0;
    end else if (w_start_ok) begin
      r_addr      <= BASE_ADDR;
      r_count     <= 16'd0;
      r_err       <= 1'b0;
      r_last_seen <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr  <= r_addr + 32'd4;
        r_count <= r_count + 16'd1;
      end
      if (w_trap) begin
        r_err <= 1'b1;
      end
      if (w_acc && in_last) begin
        r_last_seen <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid = !w_empty;
  // Mask the stale head so an empty FIFO always presents zero.
  assign out_wdata = w_empty ? 32'h0000_0000 : r_mem[r_rd_ptr];
  assign out_addr  = r_addr;
  assign count     = r_count;
  assign err       = r_err;
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder with hand-computed machine words.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mnem;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic        done;
  logic        err;
  logic [15:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(
    .DEPTH     (4),
    .BASE_ADDR (32'h0000_3000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mnem   (in_mnem),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .in_target (in_target),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_wdata (out_wdata),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for in_ready, then presents one instruction for one edge.
  task automatic push(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tg, input logic last);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) check("push_wait_in_ready", {31'd0, in_ready}, 32'd1);
    in_mnem   = m;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_imm    = imm;
    in_target = tg;
    in_last   = last;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  logic [31:0] bp_exp [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mnem = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
    in_imm = 16'd0; in_target = 26'd0; in_last = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_addr",  out_addr,           32'h0000_3000);
    check("rst_out_wdata", out_wdata,          32'h0000_0000);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    check("rst_count",     {16'd0, count},     32'd0);

    reset = 1'b1;
    tick();
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);

    // Basic encode, single-word program
    pulse_start();
    check("run_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    push(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    check("add_wdata",      out_wdata, 32'h0022_1820);
    check("add_addr",       out_addr,  32'h0000_3000);
    check("add_in_ready",   {31'd0, in_ready}, 32'd0);
    tick();
    check("p1_done",        {31'd0, done},  32'd1);
    check("p1_count",       {16'd0, count}, 32'd1);
    check("p1_addr",        out_addr,       32'h0000_3004);
    check("p1_out_valid",   {31'd0, out_valid}, 32'd0);

    // Field coverage with simultaneous push/pop; unused fields carry junk
    pulse_start();
    check("p2_start_done",  {31'd0, done},  32'd0);
    check("p2_start_count", {16'd0, count}, 32'd0);
    check("p2_start_addr",  out_addr,       32'h0000_3000);
    push(4'd2, 5'd0, 5'd8, 5'd7, 5'd3, 16'h1234, 26'h3FFFFFF, 1'b0);
    check("ori_wdata", out_wdata, 32'h3408_1234);
    check("ori_addr",  out_addr,  32'h0000_3000);
    push(4'd6, 5'd9, 5'd1, 5'd4, 5'd2, 16'hABCD, 26'h0, 1'b0);
    check("lui_wdata", out_wdata, 32'h3C01_ABCD);
    check("lui_addr",  out_addr,  32'h0000_3004);
    push(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    check("beq_wdata", out_wdata, 32'h1022_FFFF);
    check("beq_addr",  out_addr,  32'h0000_3008);
    push(4'd7, 5'd5, 5'd6, 5'd7, 5'd8, 16'h5555, 26'h0000C03, 1'b0);
    check("jal_wdata", out_wdata, 32'h0C00_0C03);
    check("jal_addr",  out_addr,  32'h0000_300C);
    push(4'd8, 5'd31, 5'd4, 5'd5, 5'd6, 16'h7777, 26'h0, 1'b1);
    check("jr_wdata",  out_wdata, 32'h03E0_0008);
    check("jr_addr",   out_addr,  32'h0000_3010);
    tick();
    check("p2_done",  {31'd0, done},  32'd1);
    check("p2_count", {16'd0, count}, 32'd5);

    // Backpressure: four words fill the FIFO
    pulse_start();
    out_ready = 1'b0;
    bp_exp[0] = 32'h0085_3022;
    bp_exp[1] = 32'h8FA9_0010;
    bp_exp[2] = 32'hAFAA_FFFC;
    bp_exp[3] = 32'h0002_1900;
    push(4'd1, 5'd4,  5'd5,  5'd6, 5'd9, 16'h0,    26'h0, 1'b0);
    push(4'd3, 5'd29, 5'd9,  5'd0, 5'd0, 16'h0010, 26'h0, 1'b0);
    push(4'd4, 5'd29, 5'd10, 5'd0, 5'd0, 16'hFFFC, 26'h0, 1'b0);
    push(4'd9, 5'd7,  5'd2,  5'd3, 5'd4, 16'h0,    26'h0, 1'b0);
    check("bp_full_in_ready", {31'd0, in_ready},  32'd0);
    check("bp_out_valid",     {31'd0, out_valid}, 32'd1);
    tick();
    tick();
    check("bp_hold_wdata", out_wdata, bp_exp[0]);
    check("bp_hold_addr",  out_addr,  32'h0000_3000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_drain_wdata%0d", i), out_wdata, bp_exp[i]);
      check($sformatf("bp_drain_addr%0d", i),  out_addr,  32'h0000_3000 + 32'(4 * i));
      tick();
    end
    check("bp_empty",    {31'd0, out_valid}, 32'd0);
    check("bp_count",    {16'd0, count},     32'd4);

    // start while in RUN is ignored
    pulse_start();
    check("run_start_ignored_addr",  out_addr,       32'h0000_3010);
    check("run_start_ignored_count", {16'd0, count}, 32'd4);

    // Program end with in_last on the third word
    reset = 1'b0;
    tick();
    reset = 1'b1;
    pulse_start();
    out_ready = 1'b0;
    push(4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0,    26'h0, 1'b0);
    push(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0,    26'h0, 1'b0);
    push(4'd2, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0001, 26'h0, 1'b1);
    check("last_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("last_not_done_hold", {31'd0, done}, 32'd0);
    out_ready = 1'b1;
    check("last_w0", out_wdata, 32'h0021_0820);
    tick();
    check("last_w1", out_wdata, 32'h0000_0000);
    check("last_done_after_pop1", {31'd0, done}, 32'd0);
    tick();
    check("last_w2", out_wdata, 32'h3400_0001);
    check("last_done_after_pop2", {31'd0, done}, 32'd0);
    tick();
    check("last_done_after_pop3", {31'd0, done},  32'd1);
    check("last_count",           {16'd0, count}, 32'd3);
    pulse_start();
    check("restart_addr",  out_addr,       32'h0000_3000);
    check("restart_done",  {31'd0, done},  32'd0);
    check("restart_count", {16'd0, count}, 32'd0);

    // Reset mid-stream with two words queued
    out_ready = 1'b0;
    push(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    push(4'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    check("mid_queued_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("mid_rst_addr",      out_addr,           32'h0000_3000);
    reset = 1'b1;
    tick();

    // Illegal mnemonic carrying in_last
    pulse_start();
    out_ready = 1'b1;
    push(4'd12, 5'd3, 5'd4, 5'd5, 5'd6, 16'hBEEF, 26'h1234567, 1'b1);
`ifdef ENC_ILLEGAL_TRAP_EN
    check("ill_out_valid", {31'd0, out_valid}, 32'd0);
    check("ill_err",       {31'd0, err},       32'd1);
    tick();
    check("ill_done",      {31'd0, done},      32'd1);
    check("ill_count",     {16'd0, count},     32'd0);
    check("ill_err_sticky", {31'd0, err},      32'd1);
`else
    check("ill_out_valid", {31'd0, out_valid}, 32'd1);
    check("ill_wdata",     out_wdata,          32'h0000_0000);
    check("ill_err",       {31'd0, err},       32'd0);
    tick();
    check("ill_done",      {31'd0, done},      32'd1);
    check("ill_count",     {16'd0, count},     32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
